// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - SRAM access bus between the instruction sequencer and data memory
interface instr_sequencer_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] sram_addr;
   logic              sram_rd_en;
   logic              sram_wr_en;
   logic [DATA_W-1:0] sram_wr_data;
   logic [DATA_W-1:0] sram_rd_data;
   logic              sram_rdy;

   modport master (
      output sram_addr, sram_rd_en, sram_wr_en, sram_wr_data,
      input  sram_rd_data, sram_rdy
   );

   modport slave (
      input  sram_addr, sram_rd_en, sram_wr_en, sram_wr_data,
      output sram_rd_data, sram_rdy
   );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - decodes one instruction per cmd_start and drives register, SRAM, ALU and jump strobes
module instr_sequencer #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 9,
   parameter int STACK_DEPTH = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              sys_rst,
   input  logic              cmd_start,
   input  logic [7:0]        instr_byte,
   input  logic [DATA_W-1:0] operand1,
   input  logic [ADDR_W-1:0] pc_next,
   input  logic [DATA_W-1:0] reg_a,
   input  logic [DATA_W-1:0] reg_b,
   input  logic [DATA_W-1:0] reg_c,
   input  logic [DATA_W-1:0] reg_d,
   input  logic [7:0]        reg_flags,
   input  logic [DATA_W-1:0] res,
   instr_sequencer_if.master sram,
   output logic              busy,
   output logic              instr_done,
   output logic              pc_hlt,
   output logic              fault,
   output logic              jmp_en,
   output logic [ADDR_W-1:0] jmp_addr,
   output logic [1:0]        instr_size,
   output logic              reg_wr_en,
   output logic [1:0]        reg_wr_addr,
   output logic [DATA_W-1:0] reg_wr_data,
   output logic [2:0]        alu_inst,
   output logic [DATA_W-1:0] op_1,
   output logic [DATA_W-1:0] op_2
);
   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_DECODE   = 4'd1;
   localparam logic [3:0] ST_EXEC     = 4'd2;
   localparam logic [3:0] ST_MEM_WAIT = 4'd3;
   localparam logic [3:0] ST_ALU_WAIT = 4'd4;
   localparam logic [3:0] ST_WB       = 4'd5;
   localparam logic [3:0] ST_DONE     = 4'd6;
   localparam logic [3:0] ST_HALT     = 4'd7;
   localparam logic [3:0] ST_FAULT    = 4'd8;

   localparam logic [3:0] K_NOP  = 4'd0;
   localparam logic [3:0] K_MOVR = 4'd1;
   localparam logic [3:0] K_MOVI = 4'd2;
   localparam logic [3:0] K_LD   = 4'd3;
   localparam logic [3:0] K_ST   = 4'd4;
   localparam logic [3:0] K_ALU  = 4'd5;
   localparam logic [3:0] K_JMP  = 4'd6;
   localparam logic [3:0] K_CALL = 4'd7;
   localparam logic [3:0] K_RET  = 4'd8;
   localparam logic [3:0] K_HLT  = 4'd9;

   localparam int TW  = $clog2(MEM_TIMEOUT + 1);
   localparam int SPW = $clog2(STACK_DEPTH) + 1;

   logic [3:0]        state;
   logic [7:0]        ir;
   logic [DATA_W-1:0] op1;
   logic [ADDR_W-1:0] ret_pc;
   logic [TW-1:0]     tmo_cnt;
   logic [SPW-1:0]    sp;
   logic [SPW-1:0]    sp_m1;
   logic [ADDR_W-1:0] stack [STACK_DEPTH];

   logic [3:0]        kind;
   logic [1:0]        size;
   logic [DATA_W-1:0] rd_val;
   logic [DATA_W-1:0] rs_val;
   logic              jmp_taken;
   logic              unused_flags;

   assign unused_flags = ^reg_flags[7:2];
   assign sp_m1        = sp - SPW'(1);

   always_comb begin
      kind = K_NOP;
      size = 2'd1;
      casez (ir)
         8'b0000_????: kind = K_MOVR;
         8'b0001_??00: begin kind = K_MOVI; size = 2'd2; end
         8'b0010_??00: begin kind = K_LD;   size = 2'd2; end
         8'b0011_??00: begin kind = K_ST;   size = 2'd2; end
         8'b1???_????: kind = K_ALU;
         8'b0101_00??: begin kind = K_JMP;  size = 2'd2; end
         8'h54:        begin kind = K_CALL; size = 2'd2; end
         8'h55:        kind = K_RET;
         8'h5F:        kind = K_HLT;
         default:      kind = K_NOP;
      endcase
   end

   // dd lives in bits 3:2 (also the store source), ss in bits 1:0
   always_comb begin
      rd_val = reg_a;
      rs_val = reg_a;
      case (ir[3:2])
         2'd0: rd_val = reg_a;
         2'd1: rd_val = reg_b;
         2'd2: rd_val = reg_c;
         default: rd_val = reg_d;
      endcase
      case (ir[1:0])
         2'd0: rs_val = reg_a;
         2'd1: rs_val = reg_b;
         2'd2: rs_val = reg_c;
         default: rs_val = reg_d;
      endcase
   end

   always_comb begin
      jmp_taken = 1'b0;
      case (ir[1:0])
         2'd0: jmp_taken = 1'b1;
         2'd1: jmp_taken = reg_flags[1];
         2'd2: jmp_taken = ~reg_flags[1];
         default: jmp_taken = reg_flags[0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (!sys_rst) begin
         state             <= ST_IDLE;
         ir                <= '0;
         op1               <= '0;
         ret_pc            <= '0;
         tmo_cnt           <= '0;
         sp                <= '0;
         busy              <= 1'b0;
         instr_done        <= 1'b0;
         pc_hlt            <= 1'b0;
         fault             <= 1'b0;
         jmp_en            <= 1'b0;
         jmp_addr          <= '0;
         instr_size        <= '0;
         reg_wr_en         <= 1'b0;
         reg_wr_addr       <= '0;
         reg_wr_data       <= '0;
         alu_inst          <= '0;
         op_1              <= '0;
         op_2              <= '0;
         sram.sram_addr    <= '0;
         sram.sram_rd_en   <= 1'b0;
         sram.sram_wr_en   <= 1'b0;
         sram.sram_wr_data <= '0;
      end else begin
         reg_wr_en  <= 1'b0;
         jmp_en     <= 1'b0;
         instr_done <= 1'b0;
         case (state)
            ST_IDLE: if (cmd_start) begin
               ir     <= instr_byte;
               op1    <= operand1;
               ret_pc <= pc_next;
               busy   <= 1'b1;
               state  <= ST_DECODE;
            end
            ST_DECODE: begin
               instr_size <= size;
               state      <= ST_EXEC;
            end
            ST_EXEC: begin
               state      <= ST_DONE;
               instr_done <= 1'b1;
               case (kind)
                  K_MOVR, K_MOVI: begin
                     reg_wr_en   <= 1'b1;
                     reg_wr_addr <= ir[3:2];
                     reg_wr_data <= (kind == K_MOVI) ? op1 : rs_val;
                  end
                  K_LD, K_ST: begin
                     sram.sram_addr    <= op1;
                     sram.sram_rd_en   <= (kind == K_LD);
                     sram.sram_wr_en   <= (kind == K_ST);
                     sram.sram_wr_data <= rd_val;
                     tmo_cnt           <= '0;
                     state             <= ST_MEM_WAIT;
                     instr_done        <= 1'b0;
                  end
                  K_ALU: begin
                     alu_inst   <= ir[6:4];
                     op_1       <= rd_val;
                     op_2       <= (ir[6:4] == 3'b011 || ir[6:4] == 3'b110 ||
                                    ir[6:4] == 3'b111) ? '0 : rs_val;
                     state      <= ST_ALU_WAIT;
                     instr_done <= 1'b0;
                  end
                  K_JMP: begin
                     jmp_en   <= jmp_taken;
                     jmp_addr <= jmp_taken ? ADDR_W'(op1) : '0;
                  end
                  K_CALL, K_RET: begin
                     // stack overflow/underflow faults without touching sp or jumping
                     if ((kind == K_CALL && sp == SPW'(STACK_DEPTH)) ||
                         (kind == K_RET && sp == '0)) begin
                        state      <= ST_FAULT;
                        fault      <= 1'b1;
                        pc_hlt     <= 1'b1;
                        instr_done <= 1'b0;
                     end else if (kind == K_CALL) begin
                        stack[sp[SPW-2:0]] <= ret_pc;
                        sp       <= sp + SPW'(1);
                        jmp_en   <= 1'b1;
                        jmp_addr <= ADDR_W'(op1);
                     end else begin
                        sp       <= sp_m1;
                        jmp_en   <= 1'b1;
                        jmp_addr <= stack[sp_m1[SPW-2:0]];
                     end
                  end
                  K_HLT: begin
                     pc_hlt     <= 1'b1;
                     state      <= ST_HALT;
                     instr_done <= 1'b0;
                  end
                  default: ;
               endcase
            end
            ST_MEM_WAIT: begin
               if (sram.sram_rdy) begin
                  sram.sram_rd_en <= 1'b0;
                  sram.sram_wr_en <= 1'b0;
                  if (kind == K_LD) begin
                     reg_wr_en   <= 1'b1;
                     reg_wr_addr <= ir[3:2];
                     reg_wr_data <= sram.sram_rd_data;
                  end
                  state      <= ST_DONE;
                  instr_done <= 1'b1;
               end else if (tmo_cnt == TW'(MEM_TIMEOUT - 1)) begin
                  sram.sram_rd_en <= 1'b0;
                  sram.sram_wr_en <= 1'b0;
                  fault           <= 1'b1;
                  pc_hlt          <= 1'b1;
                  state           <= ST_FAULT;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            ST_ALU_WAIT: state <= ST_WB;
            ST_WB: begin
               reg_wr_en   <= 1'b1;
               reg_wr_addr <= ir[3:2];
               reg_wr_data <= res;
               state       <= ST_DONE;
               instr_done  <= 1'b1;
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            ST_HALT, ST_FAULT: ;
            default: begin
               fault  <= 1'b1;
               pc_hlt <= 1'b1;
               state  <= ST_FAULT;
            end
         endcase
      end
   end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameters: DATA_W, default 8, datapath width; ADDR_W, default 9, jump/return address width; STACK_DEPTH, default 4, return-stack entries (power of 2, at least 2); MEM_TIMEOUT, default 15, maximum SRAM wait cycles.
REQ-002 SHALL have ports, one per line as: name  direction  width  meaning.
- clk  in  1  sole clock, rising edge.
- sys_rst  in  1  synchronous reset, active-low.
- cmd_start  in  1  start decode of instr_byte/operand1.
- instr_byte  in  8  opcode.
- operand1  in  DATA_W  immediate, memory address or jump target.
- pc_next  in  ADDR_W  return address, pushed by CALL.
- reg_a, reg_b, reg_c, reg_d  in  DATA_W each  register-file read values.
- reg_flags  in  8  flags: bit1 zero, bit0 overflow.
- res  in  DATA_W  ALU result.
- sram_rd_data  in  DATA_W  SRAM read data.
- sram_rdy  in  1  SRAM access complete.
- busy  out  1  high whenever state is not IDLE.
- instr_done  out  1  one-cycle completion pulse.
- pc_hlt  out  1  halt the program counter.
- fault  out  1  sticky error.
- jmp_en  out  1  one-cycle jump strobe.
- jmp_addr  out  ADDR_W  jump target.
- instr_size  out  2  instruction byte count.
- sram_addr  out  DATA_W  SRAM address.
- sram_rd_en  out  1  SRAM read enable.
- sram_wr_en  out  1  SRAM write enable.
- sram_wr_data  out  DATA_W  SRAM write data.
- reg_wr_en  out  1  register write enable.
- reg_wr_addr  out  2  register index: 0=A, 1=B, 2=C, 3=D.
- reg_wr_data  out  DATA_W  register write data.
- alu_inst  out  3  ALU operation.
- op_1  out  DATA_W  ALU operand 1.
- op_2  out  DATA_W  ALU operand 2.
REQ-003 SHALL register every output.

Function
REQ-004 Opcode decode: 0000ddss = MOV rd,rs (size 1); 0001dd00 = MOV rd,imm (size 2); 0010dd00 = MOV rd,[op1] (size 2); 0011ss00 = MOV [op1],rs (size 2); 1ooodds = ALU op ooo on rd,rs (size 1).
REQ-005 Further opcodes: 0x50 JMP; 0x51 JZ; 0x52 JNZ; 0x53 JOV; 0x54 CALL; 0x55 RET (size 1); 0x5F HLT (size 1). JMP, JZ, JNZ, JOV and CALL are size 2.
REQ-006 Every other opcode SHALL be a NOP: size 1, no writes, instr_done pulse.
REQ-007 States: IDLE, DECODE, EXEC, MEM_WAIT, ALU_WAIT, WB, DONE, HALT, FAULT.
REQ-008 In IDLE, cmd_start high at edge E0 SHALL latch instr_byte, operand1 and pc_next, and enter DECODE.
REQ-009 cmd_start SHALL be ignored in every state other than IDLE.
REQ-010 Register MOV/imm: reg_wr_en high for exactly the one cycle following edge E2, with reg_wr_addr=dd and reg_wr_data equal to the source register or the imm value.
REQ-011 MOV rd,[op1]: sram_addr=op1; sram_rd_en held high from E2 until sram_rdy is sampled high; reg_wr_en pulses the cycle after, carrying the sram_rd_data captured on that edge.
REQ-012 MOV [op1],rs: sram_wr_en, sram_addr and sram_wr_data held from E2 until sram_rdy is sampled high.
REQ-013 When MEM_TIMEOUT cycles elapse in MEM_WAIT without sram_rdy, the block SHALL drop its enables and enter FAULT.
REQ-014 ALU ops: op_1=rd, op_2=rs and alu_inst=ooo from E2; ALU_WAIT occupies one cycle; res is written to rd at E4.
REQ-015 For NOT, INC and DEC (ooo = 011, 110, 111), op_2 SHALL be 0.
REQ-016 Taken jump: jmp_en high for one cycle from E2 and jmp_addr=zero-extended op1. Conditions: JZ when flags bit1=1; JNZ when bit1=0; JOV when bit0=1.
REQ-017 Not-taken jump: jmp_en=0 and jmp_addr=0.
REQ-018 CALL SHALL push the latched pc_next, then jump as JMP.
REQ-019 RET SHALL pop the stack and pulse jmp_en with jmp_addr set to the popped value.
REQ-020 CALL with the stack full, or RET with the stack empty, SHALL enter FAULT with no push, pop or jump.
REQ-021 instr_done SHALL pulse for one cycle in DONE, after which the block returns to IDLE; a new cmd_start is accepted the following cycle.
REQ-022 HLT SHALL set pc_hlt=1 and enter HALT, held until reset.
REQ-023 FAULT SHALL set fault=1 and pc_hlt=1, held until reset.
REQ-024 instr_size SHALL be valid from E1 until the next accepted cmd_start.

Reset
REQ-025 While sys_rst=0 at a rising edge: state IDLE, stack pointer 0, and all outputs 0 (busy, fault and pc_hlt included).
REQ-026 A reset asserted mid-operation SHALL abort the operation; no pending strobe or enable fires after it.

Verification
REQ-027 With reg_b=0x22, cmd_start plus instr 0x01 -> reg_wr_addr=0, reg_wr_data=0x22, and reg_wr_en a one-cycle pulse at E2.
REQ-028 Instr 0x28, op1=0x51, sram_rdy delayed 3 cycles -> sram_addr=0x51, sram_rd_en high for 4 cycles, reg_wr_addr=2; then, with sram_rdy held low, fault=1 after 15 cycles.
REQ-029 Instr 0xCB with reg_c=0x33, reg_d=0x44 -> op_1=0x33, op_2=0x44, alu_inst=100; res=0xAA written to C at E4.
REQ-030 JZ 0x57: flags=0x02 -> jmp_en pulse with jmp_addr=0x057; flags=0x00 -> jmp_en=0 and jmp_addr=0.
REQ-031 With STACK_DEPTH=4: CALL 0x10 four times with pc_next=0x1,0x2,0x3,0x4, then RET four times -> jmp_addr sequence 0x4,0x3,0x2,0x1; a 5th CALL, or a RET on the empty stack -> fault=1 and pc_hlt=1.
REQ-032 sys_rst=0 during MEM_WAIT -> all outputs 0 on the next edge; cmd_start ignored while busy; 0x5F -> pc_hlt held until reset.
